shared_gate_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one bitwise logic-gate evaluation unit (AND, NAND, OR, NOR, XOR, XNOR, INV) among NREQ requesters. It models the gate propagation delay as a fixed cycle count and returns each result tagged with the requester ID. It sits between digital client blocks and the shared gate datapath, serialising their operations.

---
 rtl/shared_gate_arbiter.sv | 240 ++++++++++++++++++++++++
 tb/tb_shared_gate_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/shared_gate_arbiter.sv
// shared_gate_arbiter
//
// Purpose:
//   Shares one bitwise logic-gate evaluation unit among NREQ requesters.
//   A round-robin arbiter picks one requester whenever the unit is idle. It
//   latches that requester's opcode and operands, models the gate
//   propagation delay as a fixed cycle count, and then returns the result
//   tagged with the requester index.
//
// Parameters:
//   NREQ  - number of requesters (2..8)
//   W     - operand/result width in bits
//   DELAY - evaluation latency in clock cycles (1..255)
//   IDW   - derived requester-index width, clog2(NREQ), minimum 1
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   req       in   [NREQ]    level request, one bit per requester
//   op        in   [3*NREQ]  opcode, requester i in bits [3i+2:3i]
//   a         in   [W*NREQ]  operand A, requester i in bits [Wi+W-1:Wi]
//   b         in   [W*NREQ]  operand B, same packing (ignored for INV)
//   gnt       out  [NREQ]    one-hot, one-cycle accept pulse
//   busy      out            high while an operation is in evaluation
//   rsp_valid out            one-cycle result strobe
//   rsp_id    out  [IDW]     requester that owns the result
//   rsp_y     out  [W]       result
//   rsp_err   out            reserved-opcode flag, pulses with rsp_valid
//
// Opcodes: 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 INV (~a), 7 reserved.

module shared_gate_arbiter #(
  parameter int NREQ  = 4,
  parameter int W     = 8,
  parameter int DELAY = 2,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req,
  input  logic [3*NREQ-1:0]   op,
  input  logic [W*NREQ-1:0]   a,
  input  logic [W*NREQ-1:0]   b,
  output logic [NREQ-1:0]     gnt,
  output logic                busy,
  output logic                rsp_valid,
  output logic [IDW-1:0]      rsp_id,
  output logic [W-1:0]        rsp_y,
  output logic                rsp_err
);

  // Reject illegal parameterisations at elaboration time.
  if (DELAY < 1 || DELAY > 255) begin : g_bad_delay
    $error("shared_gate_arbiter: DELAY must be in 1..255");
  end
  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("shared_gate_arbiter: NREQ must be in 2..8");
  end

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EVAL = 1'b1
  } state_t;

  // Opcode encodings
  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_NAND = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_INV  = 3'd6;

  // State and datapath registers
  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [2:0]      op_q, op_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;

  // Registered outputs
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [W-1:0]    rsp_y_q, rsp_y_d;
  logic            rsp_err_q, rsp_err_d;

  // Unpacked views of the per-requester input buses
  logic [2:0]      op_arr [NREQ];
  logic [W-1:0]    a_arr  [NREQ];
  logic [W-1:0]    b_arr  [NREQ];

  // Arbiter result
  logic            found;
  logic [IDW-1:0]  winner;
  logic [IDW:0]    scan_idx;

  // Gate evaluation result
  logic [W-1:0]    eval_y;
  logic            eval_err;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      op_arr[i] = op[3*i +: 3];
      a_arr[i]  = a[W*i +: W];
      b_arr[i]  = b[W*i +: W];
    end
  end

  // Round-robin scan: start at ptr and wrap modulo NREQ. The wrap is done
  // with a conditional subtract so non-power-of-two NREQ works too.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    scan_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = {1'b0, ptr_q} + (IDW+1)'(k);
      if (scan_idx >= (IDW+1)'(NREQ)) begin
        scan_idx = scan_idx - (IDW+1)'(NREQ);
      end
      if (!found && req[scan_idx[IDW-1:0]]) begin
        found  = 1'b1;
        winner = scan_idx[IDW-1:0];
      end
    end
  end

  // The shared gate unit works only on the latched operands, so inputs that
  // change after the grant never reach the result.
  always_comb begin
    eval_y   = '0;
    eval_err = 1'b0;
    case (op_q)
      OP_AND:  eval_y = a_q & b_q;
      OP_NAND: eval_y = ~(a_q & b_q);
      OP_OR:   eval_y = a_q | b_q;
      OP_NOR:  eval_y = ~(a_q | b_q);
      OP_XOR:  eval_y = a_q ^ b_q;
      OP_XNOR: eval_y = ~(a_q ^ b_q);
      OP_INV:  eval_y = ~a_q;
      default: begin
        eval_y   = '0;
        eval_err = 1'b1;
      end
    endcase
  end

  // Next-state logic. gnt, rsp_valid and rsp_err default to 0 so they are
  // single-cycle pulses. rsp_id and rsp_y hold until the next result.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    gnt_d       = '0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_y_d     = rsp_y_q;

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d       = EVAL;
          cnt_d         = 8'(DELAY - 1);
          id_d          = winner;
          op_d          = op_arr[winner];
          a_d           = a_arr[winner];
          b_d           = b_arr[winner];
          gnt_d[winner] = 1'b1;
          if (winner == IDW'(NREQ - 1)) begin
            ptr_d = '0;
          end else begin
            ptr_d = winner + 1'b1;
          end
        end
      end

      EVAL: begin
        if (cnt_q == 8'd0) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          rsp_y_d     = eval_y;
          rsp_err_d   = eval_err;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All state, including the in-flight operation, is discarded on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ptr_q       <= '0;
      id_q        <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_y_q     <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_y_q     <= rsp_y_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign gnt       = gnt_q;
  assign busy      = (state_q == EVAL);
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_shared_gate_arbiter.sv
// Directed testbench for shared_gate_arbiter (NREQ=4, W=8, DELAY=2).
// Inputs are driven 1 time unit after each rising edge, and outputs are
// sampled at the same point, so every check sees the settled value of
// one cycle.

module tb_shared_gate_arbiter;

  localparam int NREQ  = 4;
  localparam int W     = 8;
  localparam int DELAY = 2;
  localparam int IDW   = 2;

  logic                clk;
  logic                rst_n;
  logic [NREQ-1:0]     req_r;
  logic [3*NREQ-1:0]   op_r;
  logic [W*NREQ-1:0]   a_r;
  logic [W*NREQ-1:0]   b_r;
  logic [NREQ-1:0]     gnt;
  logic                busy;
  logic                rsp_valid;
  logic [IDW-1:0]      rsp_id;
  logic [W-1:0]        rsp_y;
  logic                rsp_err;

  int total;
  int bad;

  shared_gate_arbiter #(
    .NREQ  (NREQ),
    .W     (W),
    .DELAY (DELAY)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_r),
    .op        (op_r),
    .a         (a_r),
    .b         (b_r),
    .gnt       (gnt),
    .busy      (busy),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y),
    .rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int id, input logic [2:0] opc, input logic [7:0] av, input logic [7:0] bv);
    op_r[3*id +: 3] = opc;
    a_r[W*id +: W]  = av;
    b_r[W*id +: W]  = bv;
    req_r[id]       = 1'b1;
  endtask

  // One isolated operation: grant, drop req, wait DELAY, check response.
  task automatic runSingleOp(input string tag, input int id, input logic [2:0] opc,
                             input logic [7:0] av, input logic [7:0] bv,
                             input logic [7:0] exp_y, input logic exp_err);
    applyStimulus(id, opc, av, bv);
    tick();
    checkOutput({tag, "_gnt"}, 32'(gnt), 32'(4'b0001 << id));
    req_r = '0;
    tick();
    tick();
    checkOutput({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    checkOutput({tag, "_id"}, 32'(rsp_id), 32'(id));
    checkOutput({tag, "_y"}, 32'(rsp_y), 32'(exp_y));
    checkOutput({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] sweep_y [8];
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    req_r = '0;
    op_r  = '0;
    a_r   = '0;
    b_r   = '0;

    // Reset state
    tick();
    tick();
    checkOutput("rst_gnt", 32'(gnt), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_y", 32'(rsp_y), 32'd0);
    checkOutput("rst_id", 32'(rsp_id), 32'd0);
    checkOutput("rst_err", 32'(rsp_err), 32'd0);
    rst_n = 1'b1;

    // Single request from requester 0: AND F0 & 3C = 30
    applyStimulus(0, 3'd0, 8'hF0, 8'h3C);
    tick();
    checkOutput("t1_gnt", 32'(gnt), 32'h1);
    checkOutput("t1_busy_T", 32'(busy), 32'd1);
    req_r = '0;
    tick();
    checkOutput("t1_gnt_T1", 32'(gnt), 32'd0);
    checkOutput("t1_busy_T1", 32'(busy), 32'd1);
    checkOutput("t1_valid_T1", 32'(rsp_valid), 32'd0);
    tick();
    checkOutput("t1_valid", 32'(rsp_valid), 32'd1);
    checkOutput("t1_busy_T2", 32'(busy), 32'd0);
    checkOutput("t1_id", 32'(rsp_id), 32'd0);
    checkOutput("t1_y", 32'(rsp_y), 32'h30);
    checkOutput("t1_err", 32'(rsp_err), 32'd0);
    tick();
    checkOutput("t1_valid_pulse", 32'(rsp_valid), 32'd0);
    checkOutput("t1_y_hold", 32'(rsp_y), 32'h30);
    checkOutput("t1_gnt_none", 32'(gnt), 32'd0);

    // Opcode sweep from requester 2, a=A5 b=0F
    sweep_y[0] = 8'h05; sweep_y[1] = 8'hFA; sweep_y[2] = 8'hAF; sweep_y[3] = 8'h50;
    sweep_y[4] = 8'hAA; sweep_y[5] = 8'h55; sweep_y[6] = 8'h5A; sweep_y[7] = 8'h00;
    for (int k = 0; k < 8; k++) begin
      runSingleOp($sformatf("sweep_op%0d", k), 2, 3'(k), 8'hA5, 8'h0F, sweep_y[k], (k == 7));
    end

    // Late arrival: serve requester 3 (ptr wraps to 0), raise 0101 in EVAL
    applyStimulus(3, 3'd2, 8'h01, 8'h02);
    tick();
    checkOutput("late_gnt3", 32'(gnt), 32'h8);
    req_r = '0;
    op_r[2:0] = 3'd4; a_r[7:0] = 8'h11; b_r[7:0] = 8'h10;
    op_r[8:6] = 3'd0; a_r[23:16] = 8'hCC; b_r[23:16] = 8'h0F;
    req_r = 4'b0101;
    tick();
    checkOutput("late_nognt_T1", 32'(gnt), 32'd0);
    checkOutput("late_busy_T1", 32'(busy), 32'd1);
    tick();
    checkOutput("late_nognt_T2", 32'(gnt), 32'd0);
    checkOutput("late_y3", 32'(rsp_y), 32'h03);
    tick();
    checkOutput("late_gnt0", 32'(gnt), 32'h1);
    req_r = 4'b0100;
    tick();
    checkOutput("late_nognt_U1", 32'(gnt), 32'd0);
    tick();
    checkOutput("late_id0", 32'(rsp_id), 32'd0);
    checkOutput("late_y0", 32'(rsp_y), 32'h01);
    tick();
    checkOutput("late_gnt2", 32'(gnt), 32'h4);
    req_r = '0;
    tick();
    tick();
    checkOutput("late_id2", 32'(rsp_id), 32'd2);
    checkOutput("late_y2", 32'(rsp_y), 32'h0C);
    tick();

    // ptr is now 3; one op on requester 3 brings it back to 0
    runSingleOp("ptr3", 3, 3'd3, 8'h0F, 8'hF0, 8'h00, 1'b0);

    // Fairness: all requesters held active, AND FF&FF
    for (int i = 0; i < NREQ; i++) begin
      applyStimulus(i, 3'd0, 8'hFF, 8'hFF);
    end
    tick();
    checkOutput("fair_gnt0", 32'(gnt), 32'h1);
    for (int g = 1; g <= 4; g++) begin
      tick();
      checkOutput($sformatf("fair_gap%0d_a", g), 32'(gnt), 32'd0);
      tick();
      checkOutput($sformatf("fair_gap%0d_b", g), 32'(gnt), 32'd0);
      tick();
      checkOutput($sformatf("fair_gnt%0d", g), 32'(gnt), 32'(4'b0001 << (g % 4)));
    end
    req_r = '0;
    tick();
    tick();
    checkOutput("fair_last_y", 32'(rsp_y), 32'hFF);
    tick();

    // Reset mid-EVAL: requester 1, reset at T+1
    applyStimulus(1, 3'd2, 8'h12, 8'h40);
    tick();
    checkOutput("mid_gnt", 32'(gnt), 32'h2);
    tick();
    rst_n = 1'b0;
    #1;
    checkOutput("mid_busy_async", 32'(busy), 32'd0);
    checkOutput("mid_y_async", 32'(rsp_y), 32'd0);
    checkOutput("mid_valid_async", 32'(rsp_valid), 32'd0);
    checkOutput("mid_gnt_async", 32'(gnt), 32'd0);
    tick();
    checkOutput("mid_no_rsp", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    tick();
    checkOutput("mid_regrant", 32'(gnt), 32'h2);
    req_r = '0;
    tick();
    tick();
    checkOutput("mid_valid", 32'(rsp_valid), 32'd1);
    checkOutput("mid_id", 32'(rsp_id), 32'd1);
    checkOutput("mid_y", 32'(rsp_y), 32'h52);
    tick();

    // Operand stability: XOR 3C ^ 0F = 33; operands change in T+1
    applyStimulus(0, 3'd4, 8'h3C, 8'h0F);
    tick();
    checkOutput("stab_gnt", 32'(gnt), 32'h1);
    req_r = '0;
    tick();
    a_r[7:0] = 8'hFF;
    b_r[7:0] = 8'hFF;
    tick();
    checkOutput("stab_valid", 32'(rsp_valid), 32'd1);
    checkOutput("stab_y", 32'(rsp_y), 32'h33);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
